en_pulse_gen: RTL and testbench
===============================

EN_PULSE_GEN -- requirements
Module: en_pulse_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 10, the width of every timing field and internal counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-004 SHALL have port run, input, 1, start request, sampled only in IDLE or DONE.
REQ-005 SHALL have port delay, input, CNT_W, idle cycles before the first period.
REQ-006 SHALL have port per, input, CNT_W, period length in cycles.
REQ-007 SHALL have port duty, input, CNT_W, cycles per period with en high.
REQ-008 SHALL have port iter, input, CNT_W, number of periods.
REQ-009 SHALL have port en, output, 1, count-enable pulse train for the downstream counter.
REQ-010 SHALL have port busy, output, 1, high in DELAY and RUN.
REQ-011 SHALL have port done, output, 1, high in DONE until the next accepted run.

Function
REQ-012 SHALL implement FSM states IDLE, DELAY, RUN, DONE.
REQ-013 SHALL accept run in IDLE or DONE; delay, per, duty and iter are latched on that edge and ignored afterwards.
REQ-014 SHALL ignore run while busy.
REQ-015 On accept: delay>0 -> DELAY; delay==0 and iter>0 -> RUN; delay==0 and iter==0 -> DONE.
REQ-016 SHALL stay in DELAY exactly delay cycles, then go to RUN, or to DONE if iter==0.
REQ-017 In RUN, per_cnt SHALL count 0..per-1 and wrap; it_cnt SHALL increment on each wrap.
REQ-018 en SHALL be high in RUN when per_cnt < duty, otherwise low; en is low in IDLE, DELAY and DONE.
REQ-019 On per_cnt==per-1 with it_cnt==iter-1, SHALL go to DONE on the next edge.
REQ-020 per==0 SHALL be treated as per==1.
REQ-021 duty>=per SHALL give en continuously high for the whole RUN.
REQ-022 duty==0 SHALL give RUN timing with en never high.
REQ-023 Total en-high cycles per run SHALL equal iter*min(duty,max(per,1)).
REQ-024 en, busy and done SHALL be driven only from registered state, with no combinational path from any input.
REQ-025 First en SHALL appear delay+1 cycles after the run-accept edge.
REQ-026 Counters SHALL be CNT_W wide, unsigned, and never overflow, given the REQ-020 clamp.

Reset
REQ-027 When rst==0 at a clock edge, the block SHALL enter IDLE, clear all counters and drive en=0, busy=0, done=0, regardless of state.
REQ-028 Reset mid-RUN SHALL abort the sequence with no further en pulse, and a fresh run is required.
REQ-029 run asserted in the same cycle as an active reset SHALL be discarded.

Configuration
REQ-030 With macro EN_PULSE_GEN_PAUSE_EN defined, the block SHALL add input pause (1 bit).
REQ-031 While pause==1 in DELAY or RUN, all counters and the state SHALL freeze and en SHALL be 0, with busy unchanged.
REQ-032 Without EN_PULSE_GEN_PAUSE_EN, the pause port SHALL be absent and behaviour is per REQ-012..029.

Structure
REQ-033 A shared package SHALL hold the state encoding (2 bits: IDLE=0, DELAY=1, RUN=2, DONE=3) and the CNT_W default.
REQ-034 The module SHALL instantiate sub-module wrap_counter, a loadable up-counter with enable, clear and terminal-count flag, used for the delay, per and iter counters.

Verification
REQ-035 delay=0, per=4, duty=2, iter=3, run pulse -> en pattern 1100 1100 1100 starting 1 cycle after accept, then done=1, busy=0.
REQ-036 delay=5, per=3, duty=3, iter=2 -> en low 5 cycles, then high 6 consecutive cycles, then done.
REQ-037 iter=0, delay=2 -> busy for 2 cycles, no en, then done=1; per=0, duty=1, iter=4 -> en high 4 cycles.
REQ-038 rst=0 during the 2nd period of per=4, duty=2, iter=5 -> next cycle en=0, busy=0, done=0 in IDLE; run asserted while busy is ignored.
REQ-039 run in DONE with new fields -> done drops, and the new sequence matches the new fields.
REQ-040 With EN_PULSE_GEN_PAUSE_EN, pause=1 for 3 cycles mid-RUN (per=4, duty=2, iter=2) -> en held 0, and the sequence resumes at the same per_cnt with total en cycles still 4.

Source files
------------

// File: rtl/en_pulse_gen_pkg.sv
// Shared definitions for en_pulse_gen: FSM state encoding and default timing-field width.
package en_pulse_gen_pkg;

  localparam int unsigned CntWDefault = 10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDelay = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/en_pulse_gen_wrap_counter.sv
// Loadable up-counter that wraps to zero after reaching max_i; tc_o flags cnt == max_i.
module wrap_counter #(
  parameter int unsigned Width = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [Width-1:0] ld_val_i,
  input  logic             en_i,
  input  logic [Width-1:0] max_i,
  output logic [Width-1:0] cnt_o,
  output logic             tc_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  assign tc_o  = (cnt_q == max_i);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/en_pulse_gen.sv
// Delayed, duty-cycled count-enable pulse train generator. Optional pause input is
// enabled by defining EN_PULSE_GEN_PAUSE_EN. Outputs are registered from the current state.
module en_pulse_gen
  import en_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] per,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] iter,
`ifdef EN_PULSE_GEN_PAUSE_EN
  input  logic             pause,
`endif
  output logic             en,
  output logic             busy,
  output logic             done
);

  state_e           state_d, state_q;
  logic             accept, hold;
  logic [CNT_W-1:0] delay_q, per_q, duty_q, iter_q;
  logic [CNT_W-1:0] dly_cnt, per_cnt, it_cnt;
  logic             dly_tc, per_tc, it_tc;
  logic             dly_inc, per_inc, it_inc;
  logic             en_q, busy_q, done_q;
  logic             unused_cnt;

`ifdef EN_PULSE_GEN_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign dly_inc    = (state_q == StDelay) && !hold;
  assign per_inc    = (state_q == StRun) && !hold;
  assign it_inc     = per_inc && per_tc;
  assign unused_cnt = ^{dly_cnt, it_cnt};

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (run) begin
          accept = 1'b1;
          if (delay != '0)     state_d = StDelay;
          else if (iter != '0) state_d = StRun;
          else                 state_d = StDone;
        end
      end
      StDelay: if (dly_inc && dly_tc) state_d = (iter_q != '0) ? StRun : StDone;
      StRun:   if (it_inc && it_tc) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Counters are cleared on accept so every run starts from per_cnt == 0.
  wrap_counter #(.Width(CNT_W)) u_dly_cnt (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clr_i    (accept),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .en_i     (dly_inc),
    .max_i    (delay_q - CNT_W'(1)),
    .cnt_o    (dly_cnt),
    .tc_o     (dly_tc)
  );

  wrap_counter #(.Width(CNT_W)) u_per_cnt (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clr_i    (accept),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .en_i     (per_inc),
    .max_i    (per_q - CNT_W'(1)),
    .cnt_o    (per_cnt),
    .tc_o     (per_tc)
  );

  wrap_counter #(.Width(CNT_W)) u_it_cnt (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clr_i    (accept),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .en_i     (it_inc),
    .max_i    (iter_q - CNT_W'(1)),
    .cnt_o    (it_cnt),
    .tc_o     (it_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      delay_q <= '0;
      per_q   <= CNT_W'(1);
      duty_q  <= '0;
      iter_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        delay_q <= delay;
        per_q   <= (per == '0) ? CNT_W'(1) : per;
        duty_q  <= duty;
        iter_q  <= iter;
      end
      en_q   <= (state_q == StRun) && !hold && (per_cnt < duty_q);
      busy_q <= (state_q == StDelay) || (state_q == StRun);
      done_q <= (state_q == StDone);
    end
  end

  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_en_pulse_gen.sv
// Directed self-checking bench for en_pulse_gen; covers the pause option when
// EN_PULSE_GEN_PAUSE_EN is defined.
module tb_en_pulse_gen;

  logic       clk;
  logic       rst;
  logic       run;
  logic [9:0] delay, per, duty, iter;
  logic       en, busy, done;
`ifdef EN_PULSE_GEN_PAUSE_EN
  logic       pause;
`endif

  int unsigned n_cmp;
  int unsigned n_err;
  logic [63:0] env, busyv, donev;

  en_pulse_gen #(.CNT_W(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .delay (delay),
    .per   (per),
    .duty  (duty),
    .iter  (iter),
`ifdef EN_PULSE_GEN_PAUSE_EN
    .pause (pause),
`endif
    .en    (en),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept edge happens inside; fields are scrambled afterwards to prove they were latched.
  task automatic start(input logic [9:0] d, input logic [9:0] p, input logic [9:0] du,
                       input logic [9:0] it);
    @(negedge clk);
    delay = d; per = p; duty = du; iter = it; run = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0; delay = 10'h3ff; per = 10'h2aa; duty = 10'h155; iter = 10'h3ff;
  endtask

  task automatic clr_cap();
    env = '0; busyv = '0; donev = '0;
  endtask

  // Shift in one sample per cycle, each taken 1 time unit after the rising edge.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      env   = {env[62:0], en};
      busyv = {busyv[62:0], busy};
      donev = {donev[62:0], done};
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0; run = 1'b0; delay = '0; per = '0; duty = '0; iter = '0;
`ifdef EN_PULSE_GEN_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_en", 64'(en), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // delay=0 per=4 duty=2 iter=3
    start(10'd0, 10'd4, 10'd2, 10'd3);
    clr_cap(); capture(13);
    check_eq("t1_en", env, 64'b1100110011000);
    check_eq("t1_busy", busyv, 64'b1111111111110);
    check_eq("t1_done", donev, 64'b0000000000001);

    // delay=5 per=3 duty=3 iter=2, accepted from DONE
    start(10'd5, 10'd3, 10'd3, 10'd2);
    clr_cap(); capture(12);
    check_eq("t2_en", env, 64'b000001111110);
    check_eq("t2_busy", busyv, 64'b111111111110);
    check_eq("t2_done", donev, 64'b000000000001);

    // iter=0 delay=2: busy only, no en
    start(10'd2, 10'd3, 10'd1, 10'd0);
    clr_cap(); capture(4);
    check_eq("t3_en", env, 64'b0000);
    check_eq("t3_busy", busyv, 64'b1100);
    check_eq("t3_done", donev, 64'b0011);

    // per=0 clamps to 1: en high every RUN cycle
    start(10'd0, 10'd0, 10'd1, 10'd4);
    clr_cap(); capture(6);
    check_eq("t4_en", env, 64'b111100);
    check_eq("t4_busy", busyv, 64'b111100);
    check_eq("t4_done", donev, 64'b000011);

    // run while busy is ignored; reset in the 2nd period aborts
    start(10'd0, 10'd4, 10'd2, 10'd5);
    delay = 10'd0; per = 10'd1; duty = 10'd1; iter = 10'd1; run = 1'b1;
    clr_cap(); capture(5);
    check_eq("t5_en", env, 64'b11001);
    check_eq("t5_busy", busyv, 64'b11111);
    check_eq("t5_done", donev, 64'b00000);
    @(negedge clk);
    rst = 1'b0;  // run still high here and must be discarded
    @(posedge clk);
    #1;
    check_eq("t5_rst_en", 64'(en), 64'd0);
    check_eq("t5_rst_busy", 64'(busy), 64'd0);
    check_eq("t5_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    clr_cap(); capture(4);
    check_eq("t5_post_en", env, 64'b0000);
    check_eq("t5_post_busy", busyv, 64'b0000);
    check_eq("t5_post_done", donev, 64'b0000);

`ifdef EN_PULSE_GEN_PAUSE_EN
    // pause for 3 cycles after the first RUN cycle; total en stays 4
    start(10'd0, 10'd4, 10'd2, 10'd2);
    clr_cap(); capture(1);
    pause = 1'b1;
    capture(3);
    pause = 1'b0;
    capture(8);
    check_eq("tp_en", env, 64'b100010011000);
    check_eq("tp_busy", busyv, 64'b111111111110);
    check_eq("tp_done", donev, 64'b000000000001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
